// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one line-wide data memory port between two cache requesters:
//   requester 0 (data cache) and requester 1 (instruction cache). Exactly one
//   memory transaction is in flight at a time. The winner's write qualifier,
//   address and write data are latched when it is granted, so the memory sees
//   stable values for the whole transaction. After each completion the memory
//   enable is held low for one GAP cycle before the next grant can begin.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties (grant the requester that
//                               was not granted last; last-grant resets to 1,
//                               so requester 0 wins the first tie).
//                  undefined -> fixed priority on ties (requester 0 always).
//
// Parameters:
//   ADDR_W  memory byte-address width
//   DATA_W  cache-line width
//
// Ports:
//   clk_i          single clock, rising edge
//   rst_i          asynchronous, active-high reset
//   m0_enable_i    requester 0 request
//   m0_write_i     requester 0 write qualifier
//   m0_addr_i      requester 0 line address
//   m0_data_i      requester 0 write data
//   m0_ack_o       requester 0 completion pulse (same cycle as mem_ack_i)
//   m0_data_o      requester 0 read data (valid with m0_ack_o, else 0)
//   m1_*           same set for requester 1
//   mem_enable_o   memory request, high for the whole transaction
//   mem_write_o    memory write qualifier (latched)
//   mem_addr_o     memory address (latched)
//   mem_data_o     memory write data (latched)
//   mem_ack_i      memory completion
//   mem_data_i     memory read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,

  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   data_q,  data_d;

  // Arbitration result for the current IDLE cycle: 1 selects requester 1.
  logic                any_req;
  logic                grant1;

`ifdef MEM_ARB_RR_EN
  // Index of the requester granted most recently.
  logic                last_grant_q, last_grant_d;
`endif

  // -------------------------------------------------------------------------
  // Winner selection. A lone requester always wins; a tie is broken either by
  // round-robin history or by fixed priority toward requester 0.
  // -------------------------------------------------------------------------
  always_comb begin
    any_req = m0_enable_i | m1_enable_i;
    grant1  = 1'b0;
    if (m1_enable_i && !m0_enable_i) begin
      grant1 = 1'b1;
    end
`ifdef MEM_ARB_RR_EN
    else if (m1_enable_i && m0_enable_i) begin
      grant1 = ~last_grant_q;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Next state, latched transaction fields and outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m0_data_o    = '0;
    m1_ack_o     = 1'b0;
    m1_data_o    = '0;

    unique case (state_q)
      IDLE: begin
        // Decisions are made only here, so a running transaction is never
        // preempted. mem_ack_i is deliberately not looked at.
        if (any_req) begin
          state_d = grant1 ? BUSY1 : BUSY0;
          write_d = grant1 ? m1_write_i : m0_write_i;
          addr_d  = grant1 ? m1_addr_i  : m0_addr_i;
          data_d  = grant1 ? m1_data_i  : m0_data_i;
`ifdef MEM_ARB_RR_EN
          last_grant_d = grant1;
`endif
        end
      end

      BUSY0, BUSY1: begin
        // Memory side is driven only from the latched copy so the requester
        // may change or drop its inputs without disturbing the transaction.
        mem_enable_o = 1'b1;
        mem_write_o  = write_q;
        mem_addr_o   = addr_q;
        mem_data_o   = data_q;
        if (mem_ack_i) begin
          // Completion is passed straight through in the ack cycle.
          if (state_q == BUSY0) begin
            m0_ack_o  = 1'b1;
            m0_data_o = mem_data_i;
          end else begin
            m1_ack_o  = 1'b1;
            m1_data_o = mem_data_i;
          end
          state_d = GAP;
        end
      end

      GAP: begin
        // One cycle with enable low between back-to-back transactions.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and latched transaction registers. Reset forces IDLE at once, which
  // also forces every output to zero through the decode above.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Resets to 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              m0_enable_i, m0_write_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_data_i;
  logic              m0_ack_o;
  logic [DATA_W-1:0] m0_data_o;
  logic              m1_enable_i, m1_write_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_data_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m0_enable_i  (m0_enable_i),
    .m0_write_i   (m0_write_i),
    .m0_addr_i    (m0_addr_i),
    .m0_data_i    (m0_data_i),
    .m0_ack_o     (m0_ack_o),
    .m0_data_o    (m0_data_o),
    .m1_enable_i  (m1_enable_i),
    .m1_write_i   (m1_write_i),
    .m1_addr_i    (m1_addr_i),
    .m1_data_i    (m1_data_i),
    .m1_ack_o     (m1_ack_o),
    .m1_data_o    (m1_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  // One record per clock cycle: inputs held during the cycle and the outputs
  // expected in that same cycle.
  typedef struct {
    logic              m0e, m0w;
    logic [ADDR_W-1:0] m0a;
    logic [DATA_W-1:0] m0d;
    logic              m1e, m1w;
    logic [ADDR_W-1:0] m1a;
    logic [DATA_W-1:0] m1d;
    logic              ack;
    logic [DATA_W-1:0] ackd;
    logic              e_en, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_a0;
    logic [DATA_W-1:0] e_d0;
    logic              e_a1;
    logic [DATA_W-1:0] e_d1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(
    input logic m0e, input logic m0w, input logic [ADDR_W-1:0] m0a, input logic [DATA_W-1:0] m0d,
    input logic m1e, input logic m1w, input logic [ADDR_W-1:0] m1a, input logic [DATA_W-1:0] m1d,
    input logic ack, input logic [DATA_W-1:0] ackd,
    input logic e_en, input logic e_wr, input logic [ADDR_W-1:0] e_addr, input logic [DATA_W-1:0] e_data,
    input logic e_a0, input logic [DATA_W-1:0] e_d0, input logic e_a1, input logic [DATA_W-1:0] e_d1);
    vec_t v;
    v.m0e = m0e; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
    v.m1e = m1e; v.m1w = m1w; v.m1a = m1a; v.m1d = m1d;
    v.ack = ack; v.ackd = ackd;
    v.e_en = e_en; v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
    v.e_a0 = e_a0; v.e_d0 = e_d0; v.e_a1 = e_a1; v.e_d1 = e_d1;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    m0_enable_i = v.m0e; m0_write_i = v.m0w; m0_addr_i = v.m0a; m0_data_i = v.m0d;
    m1_enable_i = v.m1e; m1_write_i = v.m1w; m1_addr_i = v.m1a; m1_data_i = v.m1d;
    mem_ack_i   = v.ack; mem_data_i = v.ackd;
  endtask

  task automatic check_out(
    input string name,
    input logic e_en, input logic e_wr, input logic [ADDR_W-1:0] e_addr, input logic [DATA_W-1:0] e_data,
    input logic e_a0, input logic [DATA_W-1:0] e_d0, input logic e_a1, input logic [DATA_W-1:0] e_d1);
    logic ok;
    ok = (mem_enable_o === e_en) && (mem_write_o === e_wr) && (mem_addr_o === e_addr) &&
         (mem_data_o === e_data) && (m0_ack_o === e_a0) && (m0_data_o === e_d0) &&
         (m1_ack_o === e_a1) && (m1_data_o === e_d1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got en=%b wr=%b addr=%h data=%h a0=%b d0=%h a1=%b d1=%h | want en=%b wr=%b addr=%h data=%h a0=%b d0=%h a1=%b d1=%h",
               name, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o[31:0], m0_ack_o, m0_data_o[31:0],
               m1_ack_o, m1_data_o[31:0], e_en, e_wr, e_addr, e_data[31:0], e_a0, e_d0[31:0], e_a1, e_d1[31:0]);
    end
  endtask

  initial begin
    // ---- Tie handling straight out of reset ----
    add(1,0,'h100,0, 1,0,'h200,0, 0,0,     0,0,0,0,       0,0,     0,0);
    add(1,0,'h100,0, 1,0,'h200,0, 1,'h11,  1,0,'h100,0,   1,'h11,  0,0);
    add(1,0,'h100,0, 1,0,'h200,0, 0,0,     0,0,0,0,       0,0,     0,0);
    add(1,0,'h100,0, 1,0,'h200,0, 0,0,     0,0,0,0,       0,0,     0,0);
`ifdef MEM_ARB_RR_EN
    add(1,0,'h100,0, 1,0,'h200,0, 1,'h22,  1,0,'h200,0,   0,0,     1,'h22);
`else
    add(1,0,'h100,0, 1,0,'h200,0, 1,'h22,  1,0,'h100,0,   1,'h22,  0,0);
`endif
    add(1,0,'h100,0, 1,0,'h200,0, 0,0,     0,0,0,0,       0,0,     0,0);
    add(1,0,'h100,0, 1,0,'h200,0, 0,0,     0,0,0,0,       0,0,     0,0);
    add(1,0,'h100,0, 1,0,'h200,0, 1,'h33,  1,0,'h100,0,   1,'h33,  0,0);
    // m0 releases; m1 still holding is served after the gap.
    add(0,0,0,0,     1,0,'h200,0, 0,0,     0,0,0,0,       0,0,     0,0);
    add(0,0,0,0,     1,0,'h200,0, 0,0,     0,0,0,0,       0,0,     0,0);
    add(0,0,0,0,     1,0,'h200,0, 1,'h44,  1,0,'h200,0,   0,0,     1,'h44);
    add(0,0,0,0,     0,0,0,0,     0,0,     0,0,0,0,       0,0,     0,0);
    // ---- Single read by m0, memory answers ten cycles after the request ----
    add(1,0,'h400,0, 0,0,0,0,     0,0,     0,0,0,0,       0,0,     0,0);
    for (int k = 0; k < 9; k++)
      add(1,0,'h400,0, 0,0,0,0,   0,'hdead, 1,0,'h400,0,   0,0,     0,0);
    add(1,0,'h400,0, 0,0,0,0,     1,'h5,   1,0,'h400,0,   1,'h5,   0,0);
    // Acks arriving in GAP and IDLE are ignored.
    add(0,0,0,0,     0,0,0,0,     1,'h66,  0,0,0,0,       0,0,     0,0);
    add(0,0,0,0,     0,0,0,0,     1,'h77,  0,0,0,0,       0,0,     0,0);
    add(0,0,0,0,     0,0,0,0,     0,0,     0,0,0,0,       0,0,     0,0);
    // ---- m1 write; its inputs change and drop after grant ----
    add(0,0,0,0,     1,1,'h20,'hAA,   0,0,     0,0,0,0,       0,0,     0,0);
    add(0,0,0,0,     1,0,'h999,'hBB,  0,0,     1,1,'h20,'hAA, 0,0,     0,0);
    add(0,0,0,0,     1,0,'h999,'hBB,  0,0,     1,1,'h20,'hAA, 0,0,     0,0);
    add(0,0,0,0,     0,0,'h999,'hBB,  1,'h33,  1,1,'h20,'hAA, 0,0,     1,'h33);
    add(0,0,0,0,     0,0,0,0,         0,0,     0,0,0,0,       0,0,     0,0);

    // ---- Reset state ----
    rst_i = 1'b1;
    m0_enable_i = 0; m0_write_i = 0; m0_addr_i = 0; m0_data_i = 0;
    m1_enable_i = 0; m1_write_i = 0; m1_addr_i = 0; m1_data_i = 0;
    mem_ack_i = 1'b1; mem_data_i = 'h99;
    @(negedge clk_i);
    check_out("reset_state", 0,0,0,0, 0,0, 0,0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // ---- Table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(negedge clk_i);
      check_out($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_data,
                vecs[i].e_a0, vecs[i].e_d0, vecs[i].e_a1, vecs[i].e_d1);
      @(posedge clk_i); #1;
    end

    // ---- Asynchronous reset in the middle of a BUSY0 transaction ----
    m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 'h400; m0_data_i = 0;
    m1_enable_i = 0; mem_ack_i = 0; mem_data_i = 0;
    @(negedge clk_i);
    check_out("rst_pre_idle", 0,0,0,0, 0,0, 0,0);
    @(posedge clk_i); #1;
    mem_ack_i = 1; mem_data_i = 'h5;
    @(negedge clk_i);
    check_out("rst_pre_busy0", 1,0,'h400,0, 1,'h5, 0,0);
    #1 rst_i = 1'b1;
    #1 check_out("rst_async_clear", 0,0,0,0, 0,0, 0,0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mem_ack_i = 0; m0_enable_i = 0;
    m1_enable_i = 1; m1_write_i = 1; m1_addr_i = 'h20; m1_data_i = 'hAA;
    @(negedge clk_i);
    check_out("rst_post_idle", 0,0,0,0, 0,0, 0,0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_out("rst_post_grant", 1,1,'h20,'hAA, 0,0, 0,0);
    @(posedge clk_i); #1;
    mem_ack_i = 1; mem_data_i = 'h7;
    @(negedge clk_i);
    check_out("rst_post_ack", 1,1,'h20,'hAA, 0,0, 1,'h7);
    @(posedge clk_i); #1;
    mem_ack_i = 0; m1_enable_i = 0;
    @(negedge clk_i);
    check_out("rst_post_gap", 0,0,0,0, 0,0, 0,0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256, cache-line width.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports m0_enable_i/m0_write_i  in  1  requester 0 (data cache) request / write qualifier.
REQ-006 SHALL have ports m0_addr_i  in  ADDR_W, m0_data_i  in  DATA_W  requester 0 line address / write data.
REQ-007 SHALL have ports m0_ack_o  out  1, m0_data_o  out  DATA_W  requester 0 completion pulse / read data.
REQ-008 SHALL have m1_* ports identical to REQ-005..007 for requester 1 (instruction cache).
REQ-009 SHALL have ports mem_enable_o/mem_write_o  out  1, mem_addr_o  out  ADDR_W, mem_data_o  out  DATA_W  to data memory.
REQ-010 SHALL have ports mem_ack_i  in  1, mem_data_i  in  DATA_W  from data memory.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY0, BUSY1, GAP.
REQ-012 IDLE: no request -> stay; on request(s) SHALL pick a winner per REQ-018, latch its write/addr/data, go BUSYn.
REQ-013 BUSYn: mem_enable_o=1, mem_write_o/addr/data driven from latched values, constant for the whole transaction.
REQ-014 BUSYn with mem_ack_i=1: SHALL pulse mn_ack_o for exactly that cycle, drive mn_data_o=mem_data_i that cycle, go GAP.
REQ-015 GAP: mem_enable_o=0 for one cycle, then IDLE; guarantees enable deasserts between transactions.
REQ-016 Latency: request sampled at edge N -> mem_enable_o high from edge N+1; ack to requester same cycle as mem_ack_i (combinational pass-through).
REQ-017 Non-granted requester SHALL see ack=0 and data=0; mem_ack_i outside BUSYn SHALL be ignored.
REQ-018 Arbitration: single request -> that requester; both -> per Configuration; decision only in IDLE, never preempts.
REQ-019 Requester dropping enable during its BUSYn: memory transaction SHALL still complete; ack pulse still issued (requester may ignore).
REQ-020 Requester inputs changing during BUSYn SHALL not affect mem_* outputs (latched copy used).
REQ-021 Requester whose request arrives while other is BUSY SHALL be served after GAP with no request loss as long as it holds enable.

Reset
REQ-022 rst_i high SHALL immediately force IDLE; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, m0/m1 ack_o=0, data_o=0.
REQ-023 Reset mid-transaction SHALL abort with no ack pulse; last-grant register resets to 1 (requester 0 wins first tie).

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: tie SHALL grant requester not granted last; last-grant updated on each grant.
REQ-025 MEM_ARB_RR_EN undefined: tie SHALL always grant requester 0 (fixed priority); last-grant register absent.

Verification
REQ-026 Reset: assert rst_i mid-BUSY0 -> outputs all 0 asynchronously, no m0_ack_o, state IDLE after release.
REQ-027 Single read: m0 read addr 0x00000400, memory acks 10 cycles later with data 0x5 -> m0_ack_o one-cycle pulse, m0_data_o=0x5, mem_enable_o low one cycle after.
REQ-028 Tie, RR build: m0 and m1 both request from reset -> m0 first, then m1; repeat tie -> m1 served before m0 next round.
REQ-029 Tie, fixed build: m0 and m1 continuously request -> m0 granted every round, m1 never while m0 asserts.
REQ-030 Write hold: m1 write addr 0x20 data 0xAA, change m1_data_i to 0xBB after grant -> mem_data_o stays 0xAA until ack.
REQ-031 Spurious ack: mem_ack_i=1 in IDLE -> no mn_ack_o pulse, state unchanged.
